// File: rtl/line_mem_pkg.sv
// Shared types, default parameters and geometry helpers for the multi-channel line memory.
package line_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } ch_state_e;

    localparam int NCH_DEF        = 2;
    localparam int LINE_BITS_DEF  = 256;
    localparam int INDEX_BITS_DEF = 10;
    localparam int DELAY_DEF      = 10;

    function automatic int off_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int depth_lines(input int index_bits);
        return 1 << index_bits;
    endfunction

    // Address bits that must be zero; a shift of 32 yields an empty mask.
    function automatic logic [31:0] hi_mask(input int off, input int index_bits);
        return ~((32'd1 << (off + index_bits)) - 32'd1);
    endfunction

endpackage

// File: rtl/multi_channel_line_memory_if.sv
// Per-channel request/response bundle between a requester and the line memory.
interface multi_channel_line_memory_if
    import line_mem_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF
);
    logic [NCH-1:0]                  read;
    logic [NCH-1:0]                  write;
    logic [NCH-1:0][31:0]            addr;
    logic [NCH-1:0][LINE_BITS-1:0]   wdata;
    logic [NCH-1:0][LINE_BITS/8-1:0] wmask;
    logic [NCH-1:0]                  resp;
    logic [NCH-1:0][LINE_BITS-1:0]   rdata;
    logic                            error;

    modport master (output read, write, addr, wdata, wmask, input resp, rdata, error);
    modport slave  (input read, write, addr, wdata, wmask, output resp, rdata, error);
endinterface

// File: rtl/line_mem_channel.sv
// One request channel: FSM with countdown, request latches, rdata capture and protocol checks.
module line_mem_channel
    import line_mem_pkg::*;
#(
    parameter int LINE_BITS  = LINE_BITS_DEF,
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int DELAY      = DELAY_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read,
    input  logic                   write,
    input  logic [31:0]            addr,
    input  logic [LINE_BITS-1:0]   wdata,
    input  logic [LINE_BITS/8-1:0] wmask,
    input  logic [LINE_BITS-1:0]   mem_line,
    output logic [INDEX_BITS-1:0]  idx,
    output logic                   resp,
    output logic [LINE_BITS-1:0]   rdata,
    output logic                   wr_en,
    output logic [LINE_BITS-1:0]   wr_data,
    output logic [LINE_BITS/8-1:0] wr_mask,
    output logic                   err
);
    localparam int          OFF     = off_bits(LINE_BITS);
    localparam int          CNT_W   = $clog2(DELAY + 1);
    localparam logic [31:0] HI_MASK = hi_mask(OFF, INDEX_BITS);

    ch_state_e        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [31:0]      addr_q;
    logic             accept;
    logic             held;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        err      = 1'b0;
        held     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (read || write) begin
                    accept   = 1'b1;
                    cnt_nx   = CNT_W'(DELAY);
                    state_nx = read ? ST_READ : ST_WRITE;
                    err      = (read && write) || (addr[OFF-1:0] != '0) || ((addr & HI_MASK) != '0);
                end
            end
            ST_READ, ST_WRITE: begin
                held   = (state == ST_READ) ? read : write;
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nx = ST_IDLE;
                // The request must stay stable until the completion edge.
                if (cnt >= CNT_W'(2)) err = (addr != addr_q) || !held;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            resp  <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            resp  <= (state != ST_IDLE) && (cnt == CNT_W'(2));
            rdata <= (state == ST_READ && cnt == CNT_W'(2)) ? mem_line : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr;
            wr_data <= wdata;
            wr_mask <= wmask;
        end
    end

    assign idx   = addr_q[OFF +: INDEX_BITS];
    assign wr_en = (state == ST_WRITE) && (cnt == CNT_W'(1));

endmodule

// File: rtl/multi_channel_line_memory.sv
// Line-granular memory shared by NCH fixed-latency channels with byte-masked writes.
module multi_channel_line_memory
    import line_mem_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int LINE_BITS  = LINE_BITS_DEF,
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int DELAY      = DELAY_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    multi_channel_line_memory_if.slave  bus
);
    localparam int DEPTH  = depth_lines(INDEX_BITS);
    localparam int MASK_W = LINE_BITS / 8;

    logic [LINE_BITS-1:0]          mem [DEPTH];
    logic [INDEX_BITS-1:0]         idx [NCH];
    logic [LINE_BITS-1:0]          mem_line [NCH];
    logic [LINE_BITS-1:0]          wr_data [NCH];
    logic [MASK_W-1:0]             wr_mask [NCH];
    logic [NCH-1:0]                wr_en;
    logic [NCH-1:0]                ch_err;
    logic [NCH-1:0]                resp_v;
    logic [NCH-1:0][LINE_BITS-1:0] rdata_v;
    logic                          error;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        assign mem_line[ch] = mem[idx[ch]];

        line_mem_channel #(
            .LINE_BITS  (LINE_BITS),
            .INDEX_BITS (INDEX_BITS),
            .DELAY      (DELAY)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .read     (bus.read[ch]),
            .write    (bus.write[ch]),
            .addr     (bus.addr[ch]),
            .wdata    (bus.wdata[ch]),
            .wmask    (bus.wmask[ch]),
            .mem_line (mem_line[ch]),
            .idx      (idx[ch]),
            .resp     (resp_v[ch]),
            .rdata    (rdata_v[ch]),
            .wr_en    (wr_en[ch]),
            .wr_data  (wr_data[ch]),
            .wr_mask  (wr_mask[ch]),
            .err      (ch_err[ch])
        );
    end

    // Highest channel is applied first so lower channels overwrite contended bytes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = NCH - 1; c >= 0; c--) begin
                if (wr_en[c]) begin
                    for (int b = 0; b < MASK_W; b++) begin
                        if (wr_mask[c][b]) mem[idx[c]][b*8 +: 8] <= wr_data[c][b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          error <= 1'b0;
        else if (|ch_err) error <= 1'b1;
    end

    assign bus.resp  = resp_v;
    assign bus.rdata = rdata_v;
    assign bus.error = error;

endmodule

// File: tb/tb_multi_channel_line_memory.sv
// Directed bench for multi_channel_line_memory with NCH=2, LINE_BITS=256, INDEX_BITS=10, DELAY=4.
module tb_multi_channel_line_memory;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_channel_line_memory_if #(.NCH(2), .LINE_BITS(256)) bus ();

    multi_channel_line_memory #(
        .NCH        (2),
        .LINE_BITS  (256),
        .INDEX_BITS (10),
        .DELAY      (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the next posedge is the acceptance edge E0.
    task automatic xact(input int ch, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [255:0] d, input logic [31:0] m, input string tag,
                        output logic [255:0] rdat, output int rcyc);
        int npulse;
        int pos;
        npulse = 0;
        pos    = -1;
        rdat   = '0;
        rcyc   = -1;
        bus.read[ch]  = rd;
        bus.write[ch] = wr;
        bus.addr[ch]  = a;
        bus.wdata[ch] = d;
        bus.wmask[ch] = m;
        @(posedge clk);
        for (int k = 0; k <= D; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (bus.resp[ch]) begin
                npulse++;
                pos  = k;
                rdat = bus.rdata[ch];
                rcyc = cyc;
            end
        end
        bus.read[ch]  = 1'b0;
        bus.write[ch] = 1'b0;
        chk({tag, "_npulse"}, 256'(npulse), 256'(1));
        chk({tag, "_pos"}, 256'(pos), 256'(D - 1));
        chk({tag, "_rdata_clr"}, bus.rdata[ch], 256'(0));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_clears_error", 256'(bus.error), 256'(0));
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] rd0, rd1;
        int           rc0, rc1, npulse;
        logic         resp_seen;

        bus.read  = '0;
        bus.write = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wmask = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_resp", 256'(bus.resp), 256'(0));
        chk("reset_rdata0", bus.rdata[0], 256'(0));
        chk("reset_rdata1", bus.rdata[1], 256'(0));
        chk("reset_error", 256'(bus.error), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // Full-mask write then read
        xact(0, 1'b0, 1'b1, 32'h40, {32{8'hA5}}, 32'hFFFF_FFFF, "wr40", rd0, rc0);
        xact(0, 1'b1, 1'b0, 32'h40, '0, '0, "rd40", rd0, rc0);
        chk("rd40_data", rd0, {32{8'hA5}});

        // Partial-mask write over a known line
        xact(0, 1'b0, 1'b1, 32'h60, {32{8'h22}}, 32'hFFFF_FFFF, "wr60_full", rd0, rc0);
        xact(0, 1'b0, 1'b1, 32'h60, {32{8'h11}}, 32'h0000_000F, "wr60_part", rd0, rc0);
        xact(1, 1'b1, 1'b0, 32'h60, '0, '0, "rd60", rd0, rc0);
        chk("rd60_data", rd0, {{28{8'h22}}, {4{8'h11}}});

        // Same-edge full-mask conflict: channel 0 wins
        fork
            xact(0, 1'b0, 1'b1, 32'h80, {32{8'h01}}, 32'hFFFF_FFFF, "cf80_0", rd0, rc0);
            xact(1, 1'b0, 1'b1, 32'h80, {32{8'h02}}, 32'hFFFF_FFFF, "cf80_1", rd1, rc1);
        join
        chk("cf80_same_resp_cycle", 256'(rc0), 256'(rc1));
        xact(1, 1'b1, 1'b0, 32'h80, '0, '0, "rd80", rd0, rc0);
        chk("rd80_data", rd0, {32{8'h01}});

        // Byte-wise conflict: only the lower 16 bytes are contended
        fork
            xact(0, 1'b0, 1'b1, 32'hA0, {32{8'h01}}, 32'h0000_FFFF, "cfA0_0", rd0, rc0);
            xact(1, 1'b0, 1'b1, 32'hA0, {32{8'h02}}, 32'hFFFF_FFFF, "cfA0_1", rd1, rc1);
        join
        xact(0, 1'b1, 1'b0, 32'hA0, '0, '0, "rdA0", rd0, rc0);
        chk("rdA0_data", rd0, {{16{8'h02}}, {16{8'h01}}});
        chk("clean_error", 256'(bus.error), 256'(0));

        // Back-to-back requests on channel 0
        xact(0, 1'b1, 1'b0, 32'h40, '0, '0, "b2b_a", rd0, rc0);
        xact(0, 1'b1, 1'b0, 32'h60, '0, '0, "b2b_b", rd1, rc1);
        chk("b2b_spacing", 256'(rc1 - rc0), 256'(5));
        chk("b2b_a_data", rd0, {32{8'hA5}});
        chk("b2b_b_data", rd1, {{28{8'h22}}, {4{8'h11}}});

        // Reset in the middle of a write
        xact(0, 1'b0, 1'b1, 32'hC0, {32{8'h33}}, 32'hFFFF_FFFF, "wrC0", rd0, rc0);
        resp_seen = 1'b0;
        bus.write[0] = 1'b1;
        bus.addr[0]  = 32'hC0;
        bus.wdata[0] = {32{8'h44}};
        bus.wmask[0] = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        resp_seen |= bus.resp[0];
        @(posedge clk);
        @(negedge clk);
        resp_seen |= bus.resp[0];
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            resp_seen |= bus.resp[0];
        end
        bus.write[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            resp_seen |= bus.resp[0];
        end
        chk("rstmid_no_resp", 256'(resp_seen), 256'(0));
        chk("rstmid_error", 256'(bus.error), 256'(0));
        xact(0, 1'b1, 1'b0, 32'hC0, '0, '0, "rdC0", rd0, rc0);
        chk("rdC0_unchanged", rd0, {32{8'h33}});

        // Protocol errors: read and write together
        xact(1, 1'b1, 1'b1, 32'h40, {32{8'hEE}}, 32'hFFFF_FFFF, "err_rw", rd0, rc0);
        chk("err_rw_flag", 256'(bus.error), 256'(1));
        repeat (3) @(negedge clk);
        chk("err_rw_sticky", 256'(bus.error), 256'(1));
        pulse_rst();

        // Misaligned address still completes on the truncated index
        xact(0, 1'b1, 1'b0, 32'h44, '0, '0, "err_mis", rd0, rc0);
        chk("err_mis_flag", 256'(bus.error), 256'(1));
        chk("err_mis_data", rd0, {32{8'hA5}});
        pulse_rst();

        // Address beyond the array
        xact(0, 1'b1, 1'b0, 32'h0001_0000, '0, '0, "err_hi", rd0, rc0);
        chk("err_hi_flag", 256'(bus.error), 256'(1));
        pulse_rst();

        // Address changed while a read is in flight
        npulse = 0;
        bus.read[0] = 1'b1;
        bus.addr[0] = 32'h40;
        @(posedge clk);
        @(negedge clk);
        chk("err_chg_before", 256'(bus.error), 256'(0));
        bus.addr[0] = 32'h60;
        for (int k = 1; k <= D; k++) begin
            @(negedge clk);
            if (bus.resp[0]) begin
                npulse++;
                rd0 = bus.rdata[0];
            end
        end
        bus.read[0] = 1'b0;
        chk("err_chg_npulse", 256'(npulse), 256'(1));
        chk("err_chg_data", rd0, {32{8'hA5}});
        chk("err_chg_flag", 256'(bus.error), 256'(1));
        pulse_rst();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_line_memory.md
MULTI_CHANNEL_LINE_MEMORY -- requirements
Module: multi_channel_line_memory

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent request channels, 1..4.
REQ-002 SHALL have parameter LINE_BITS, default 256: line width, power of two, 64..512.
REQ-003 SHALL have parameter INDEX_BITS, default 10: DEPTH = 2**INDEX_BITS lines.
REQ-004 SHALL have parameter DELAY, default 10: cycles from acceptance to completion, >= 2.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port read, input, NCH: per-channel read request, level held until resp.
REQ-008 SHALL have port write, input, NCH: per-channel write request, level held until resp.
REQ-009 SHALL have port addr, input, NCH x 32: per-channel byte address.
REQ-010 SHALL have port wdata, input, NCH x LINE_BITS: per-channel write line.
REQ-011 SHALL have port wmask, input, NCH x LINE_BITS/8: per-channel byte enables, 1 = write byte.
REQ-012 SHALL have port resp, output, NCH: per-channel one-cycle completion pulse.
REQ-013 SHALL have port rdata, output, NCH x LINE_BITS: per-channel read line, valid only while resp is high.
REQ-014 SHALL have port error, output, 1: sticky protocol-violation flag.

Function
REQ-015 SHALL use OFF = log2(LINE_BITS/8); line index = addr[OFF +: INDEX_BITS].
REQ-016 SHALL run one FSM per channel with states IDLE, READ, WRITE and a down-counter.
REQ-017 SHALL, in IDLE with read or write high at edge E0, latch addr, wdata and wmask, load counter = DELAY and enter READ or WRITE.
REQ-018 SHALL drive resp high for exactly the cycle after edge E0+DELAY-1, low at all other times.
REQ-019 SHALL return the channel to IDLE at edge E0+DELAY; the earliest next acceptance is edge E0+DELAY+1.
REQ-020 SHALL, for a read, load rdata at edge E0+DELAY-1 from the array as it stands before that edge's writes; otherwise rdata = 0.
REQ-021 SHALL, for a write, update only bytes with wmask=1 of the latched line at edge E0+DELAY, using the values latched at E0.
REQ-022 SHALL resolve same-edge writes to one line byte-wise: the lower channel index wins each byte both enable.
REQ-023 SHALL run channels independently; each channel's timing is unaffected by activity on other channels.
REQ-024 SHALL set error when read and write are both high on one channel.
REQ-025 SHALL set error on a request with addr[OFF-1:0] != 0.
REQ-026 SHALL set error on a request with addr bits above OFF+INDEX_BITS nonzero.
REQ-027 SHALL set error in READ/WRITE when addr differs from the latched address or the active request bit drops before E0+DELAY.
REQ-028 SHALL, on a request that raises error, still accept and complete it normally, with the index taken per REQ-015.
REQ-029 SHALL hold error at 1 until reset.

Reset
REQ-030 SHALL, while rst is high at an edge, force all FSMs to IDLE, counters to 0, resp = 0, rdata = 0 and error = 0.
REQ-031 SHALL abandon any in-flight access on reset; a write not yet committed SHALL NOT modify the array.
REQ-032 SHALL leave array contents unchanged by reset; no initialisation beyond the simulator default.

Structure
REQ-033 SHALL place the FSM state enum, default parameter constants and the OFF/DEPTH derivation functions in package line_mem_pkg.
REQ-034 SHALL implement per-channel FSM, counter, latches and checks in sub-module line_mem_channel, instantiated NCH times.
REQ-035 SHALL keep the storage array and write-merge logic in the top module.

Verification (NCH=2, LINE_BITS=256, INDEX_BITS=10, DELAY=4)
REQ-036 SHALL check full-mask write followed by read: ch0 write 0x40, wdata=0xA5.., wmask=all-1 -> resp at E0+3; then ch0 read 0x40 -> rdata=0xA5.. with resp one cycle.
REQ-037 SHALL check partial-mask write: wmask=0x0000000F with wdata=0x11.. over line 0x22.. -> read gives bytes 0-3 = 0x11, bytes 4-31 = 0x22.
REQ-038 SHALL check a same-edge write conflict: ch0 and ch1 write 0x80 with full masks, data 0x01.. and 0x02.. -> read returns 0x01...
REQ-039 SHALL check protocol errors: read=write=1 on ch1; addr=0x44; addr=0x10000; addr changed mid-read -> error=1 each case, held until rst.
REQ-040 SHALL check reset mid-operation: rst at E0+2 of a write to 0xC0 -> resp never pulses, line 0xC0 unchanged, error=0.
REQ-041 SHALL check back-to-back throughput: ch0 re-requests at E0+5 -> accepted; resp pulses 5 cycles apart.
